// File: rtl/timer_counter.sv
// timer_counter: bridge-mapped countdown timer (CTRL/PRESET/COUNT at Addr 0/1/2, Dout combinational read, IRQ = irq_pend & IM)
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        fire;
  always_comb begin
    ctrl_wr     = WE && Addr == 2'd0;
    preset_wr   = WE && Addr == 2'd1;
    auto_reload = ctrl[2:1] == 2'd1;
    fire        = state == CNT && ctrl[0] && count <= 32'd1;
    Dout        = Addr == 2'd0 ? {28'd0, ctrl} : Addr == 2'd1 ? preset : Addr == 2'd2 ? count : 32'd0;
    IRQ         = irq_pend & ctrl[3];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= PRESET_RST;
      count    <= 32'd0;
      irq_pend <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= Din[3:0];
      if (preset_wr) preset <= Din;
      // a new request beats any clear in the same edge
      irq_pend <= fire | (irq_pend & ~(auto_reload ? state == INT : ctrl_wr | preset_wr));
      case (state)
        IDLE: state <= ctrl[0] ? LOAD : IDLE;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) state <= IDLE;
          else if (count > 32'd1) count <= count - 32'd1;
          else begin
            count <= 32'd0;
            state <= INT;
          end
        end
        INT: begin
          state <= auto_reload ? LOAD : IDLE;
          // one-shot disarms itself unless software is writing CTRL this edge
          if (!auto_reload && !ctrl_wr) ctrl[0] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: vector table, corner-case sequences and randomized run against a reference model of timer_counter
module tb_timer_counter;
  localparam logic [31:0] PRESET_RST = 32'h0000_0000;
  localparam int S_IDLE = 0, S_LOAD = 1, S_CNT = 2, S_INT = 3;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_state = S_IDLE;
  logic        m_en = 1'b0;
  logic        m_im = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic [31:0] m_pre = PRESET_RST;
  logic [31:0] m_cnt = 32'd0;
  logic        m_pend = 1'b0;
  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] ed;
    logic        ei;
  } vec_t;
  vec_t tv[12];

  timer_counter #(.PRESET_RST(PRESET_RST)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic mstep(input logic w, input logic [1:0] a, input logic [31:0] d, input logic r);
    logic cw, pw, ar, set_p, clr_p;
    if (r) begin
      m_state = S_IDLE; m_en = 0; m_mode = 0; m_im = 0;
      m_pre = PRESET_RST; m_cnt = 0; m_pend = 0;
    end else begin
      cw = w && a == 2'd0;
      pw = w && a == 2'd1;
      ar = m_mode == 2'd1;
      set_p = 0;
      clr_p = ar ? (m_state == S_INT) : (cw || pw);
      case (m_state)
        S_IDLE: if (m_en) m_state = S_LOAD;
        S_LOAD: begin m_cnt = m_pre; m_state = S_CNT; end
        S_CNT: begin
          if (!m_en) m_state = S_IDLE;
          else if (m_cnt > 1) m_cnt = m_cnt - 1;
          else begin m_cnt = 0; set_p = 1; m_state = S_INT; end
        end
        default: begin m_state = ar ? S_LOAD : S_IDLE; if (!ar) m_en = 0; end
      endcase
      if (cw) begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
      if (pw) m_pre = d;
      m_pend = set_p ? 1'b1 : clr_p ? 1'b0 : m_pend;
    end
  endtask

  function automatic logic [31:0] mdout(input logic [1:0] ra);
    case (ra)
      2'd0: return {28'd0, m_im, m_mode, m_en};
      2'd1: return m_pre;
      2'd2: return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [1:0] ra);
    WE = w; Addr = a; Din = d;
    @(posedge clk);
    mstep(w, a, d, reset);
    #1;
    WE = 1'b0; Addr = ra;
    #1;
  endtask

  task automatic idle(input logic [1:0] ra);
    cyc(1'b0, 2'd0, 32'd0, ra);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 2'd0, 32'hF, 2'd0);
    reset = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 2'd1, 32'd3,    2'd1, 32'd3, 1'b0};
    tv[1]  = '{1'b1, 2'd0, 32'h9,    2'd0, 32'h9, 1'b0};
    tv[2]  = '{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b0};
    tv[3]  = '{1'b0, 2'd0, 32'd0,    2'd2, 32'd3, 1'b0};
    tv[4]  = '{1'b0, 2'd0, 32'd0,    2'd2, 32'd2, 1'b0};
    tv[5]  = '{1'b0, 2'd0, 32'd0,    2'd2, 32'd1, 1'b0};
    tv[6]  = '{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b1};
    tv[7]  = '{1'b0, 2'd0, 32'd0,    2'd0, 32'h8, 1'b1};
    tv[8]  = '{1'b0, 2'd0, 32'd0,    2'd0, 32'h8, 1'b1};
    tv[9]  = '{1'b1, 2'd2, 32'h55,   2'd2, 32'd0, 1'b1};
    tv[10] = '{1'b1, 2'd3, 32'hFFFF, 2'd3, 32'd0, 1'b1};
    tv[11] = '{1'b1, 2'd0, 32'h8,    2'd0, 32'h8, 1'b0};

    reset = 1'b1;
    cyc(1'b1, 2'd0, 32'hF, 2'd0);
    cyc(1'b1, 2'd0, 32'hF, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Addr = 2'(i);
      #1;
      chk($sformatf("reset dout a%0d", i), Dout, 32'd0);
      chk($sformatf("reset irq a%0d", i), {31'd0, IRQ}, 32'd0);
    end

    foreach (tv[i]) begin
      cyc(tv[i].w, tv[i].a, tv[i].d, tv[i].ra);
      chk($sformatf("vec%0d dout", i), Dout, tv[i].ed);
      chk($sformatf("vec%0d irq", i), {31'd0, IRQ}, {31'd0, tv[i].ei});
    end

    do_reset();
    cyc(1'b1, 2'd1, 32'd2, 2'd2);
    cyc(1'b1, 2'd0, 32'hB, 2'd2);
    for (int k = 2; k < 18; k++) begin
      idle(2'd2);
      chk($sformatf("reload irq k%0d", k), {31'd0, IRQ}, {31'd0, k >= 5 && (k - 5) % 4 == 0});
      chk($sformatf("reload count k%0d", k), Dout,
          k < 3 ? 32'd0 : (k - 3) % 4 == 0 ? 32'd2 : (k - 3) % 4 == 1 ? 32'd1 : 32'd0);
    end

    do_reset();
    cyc(1'b1, 2'd1, 32'd3, 2'd0);
    cyc(1'b1, 2'd0, 32'h1, 2'd0);
    for (int k = 2; k < 8; k++) begin
      idle(2'd0);
      chk($sformatf("mask irq k%0d", k), {31'd0, IRQ}, 32'd0);
      chk($sformatf("mask ctrl k%0d", k), Dout, k >= 7 ? 32'd0 : 32'd1);
    end
    cyc(1'b1, 2'd0, 32'h8, 2'd0);
    chk("mask clear ctrl", Dout, 32'h8);
    chk("mask clear irq", {31'd0, IRQ}, 32'd0);
    idle(2'd0);
    chk("mask clear irq later", {31'd0, IRQ}, 32'd0);

    do_reset();
    cyc(1'b1, 2'd1, 32'd3, 2'd0);
    cyc(1'b1, 2'd0, 32'h3, 2'd0);
    for (int k = 2; k < 6; k++) begin
      idle(2'd0);
      chk($sformatf("expose pre irq k%0d", k), {31'd0, IRQ}, 32'd0);
    end
    cyc(1'b1, 2'd0, 32'hB, 2'd0);
    chk("expose irq", {31'd0, IRQ}, 32'd1);
    chk("expose ctrl", Dout, 32'hB);
    idle(2'd2);
    chk("expose pulse end", {31'd0, IRQ}, 32'd0);
    chk("expose load count", Dout, 32'd0);

    do_reset();
    cyc(1'b1, 2'd1, 32'd10, 2'd2);
    cyc(1'b1, 2'd0, 32'h1, 2'd2);
    for (int k = 2; k < 8; k++) begin
      idle(2'd2);
      chk($sformatf("freeze count k%0d", k), Dout, k < 3 ? 32'd0 : 32'(13 - k));
    end
    cyc(1'b1, 2'd0, 32'h0, 2'd2);
    chk("freeze last dec", Dout, 32'd5);
    idle(2'd2);
    chk("freeze hold1", Dout, 32'd5);
    idle(2'd2);
    chk("freeze hold2", Dout, 32'd5);
    cyc(1'b1, 2'd0, 32'h1, 2'd2);
    idle(2'd2);
    chk("reenable load", Dout, 32'd5);
    idle(2'd2);
    chk("reenable reload", Dout, 32'd10);

    do_reset();
    cyc(1'b1, 2'd1, 32'd0, 2'd0);
    cyc(1'b1, 2'd0, 32'h9, 2'd0);
    idle(2'd0);
    chk("p0 irq e1", {31'd0, IRQ}, 32'd0);
    idle(2'd0);
    chk("p0 irq e2", {31'd0, IRQ}, 32'd0);
    idle(2'd0);
    chk("p0 irq e3", {31'd0, IRQ}, 32'd1);

    do_reset();
    cyc(1'b1, 2'd1, 32'd3, 2'd1);
    cyc(1'b1, 2'd0, 32'h9, 2'd1);
    for (int k = 2; k < 6; k++) idle(2'd1);
    cyc(1'b1, 2'd1, 32'd7, 2'd1);
    chk("setwins irq", {31'd0, IRQ}, 32'd1);
    chk("setwins preset", Dout, 32'd7);
    idle(2'd0);
    chk("setwins irq hold", {31'd0, IRQ}, 32'd1);
    chk("setwins ctrl", Dout, 32'h8);
    cyc(1'b1, 2'd1, 32'd7, 2'd0);
    chk("preset write clears", {31'd0, IRQ}, 32'd0);

    do_reset();
    cyc(1'b1, 2'd1, 32'd1, 2'd0);
    cyc(1'b1, 2'd0, 32'h9, 2'd0);
    idle(2'd0);
    idle(2'd0);
    idle(2'd0);
    chk("ctrlwins pre irq", {31'd0, IRQ}, 32'd1);
    cyc(1'b1, 2'd0, 32'h9, 2'd0);
    chk("ctrlwins ctrl", Dout, 32'h9);
    chk("ctrlwins irq", {31'd0, IRQ}, 32'd0);
    idle(2'd2);
    idle(2'd2);
    chk("ctrlwins count", Dout, 32'd1);
    idle(2'd2);
    chk("ctrlwins irq again", {31'd0, IRQ}, 32'd1);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      reset = $urandom_range(0, 199) == 0;
      w = $urandom_range(0, 3) == 0;
      a = 2'($urandom_range(0, 3));
      d = a == 2'd1 ? 32'($urandom_range(0, 6)) : $urandom;
      cyc(w, a, d, 2'($urandom_range(0, 3)));
      chk("rand dout", Dout, mdout(Addr));
      chk("rand irq", {31'd0, IRQ}, {31'd0, m_pend & m_im});
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Programmable countdown timer on the system bridge.
- One of the hardware interrupt sources that drives a bit of the CPU coprocessor's HWInt[5:0] vector; this block is the requesting end of that interrupt path.
- Software programs it with stores and polls it with loads. The external bridge decodes a 16-byte window and passes the word offset plus a write strobe.
- Its IRQ output is level-registered, so the coprocessor can latch it into its pending field.

Parameters:
- PRESET_RST, 32'h0000_0000, reset value of PRESET register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  2  word offset Addr[3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- WE  input  1  write strobe, sampled at rising edge.
- Din  input  32  store data.
- Dout  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request to coprocessor HWInt bit; registered.

Behaviour:
- Registers:
  - CTRL bit0 = Enable; bits[2:1] = Mode (0 one-shot, 1 auto-reload, 2/3 treated as 0); bit3 = IM (interrupt mask). Other bits read 0.
  - PRESET is 32-bit read/write.
  - COUNT is 32-bit read-only; writes are ignored.
  - Addr 3 reads 0; writes to it are ignored.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_pend=0, IRQ=0. Reset overrides any WE in the same cycle.
- Dout: CTRL zero-extended above bit3, PRESET, COUNT, or 0. Zero-latency read.
- IRQ = irq_pend & IM. irq_pend is a flop, so IRQ changes only after a clock edge or a CTRL write.
- FSM states: IDLE, LOAD, CNT, INT. All decisions use pre-edge register values.
  - IDLE: Enable=1 -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - Enable=0 -> IDLE, COUNT holds.
    - Else if COUNT>1: COUNT<=COUNT-1, stay in CNT.
    - Else (COUNT 0 or 1): COUNT<=0, irq_pend<=1 -> INT.
  - INT, Mode 1: irq_pend<=0 -> LOAD. IRQ is a one-cycle pulse per period, period = PRESET+2 cycles (PRESET>=1).
  - INT, other modes: Enable<=0 -> IDLE; irq_pend stays 1.
- irq_pend clear rules:
  - Mode 0: cleared by any write to CTRL or PRESET.
  - Mode 1: cleared when leaving INT.
- Simultaneous software write and FSM update:
  - A software write to CTRL wins over the FSM clearing Enable in INT.
  - The write still applies, but the state transition follows the pre-edge state rule.
  - Writing PRESET during CNT does not alter COUNT until the next LOAD.
- Setting irq_pend in the same edge as a CTRL/PRESET write: the set wins.
- Mid-count Enable=0: counting freezes and the FSM returns to IDLE. Re-enabling reloads from PRESET and does not resume.
- PRESET=0 behaves like PRESET=1: LOAD, then CNT, then INT.
- No arithmetic wrap: COUNT never decrements below 0.
- Clearing IM masks IRQ immediately but does not clear irq_pend. Setting IM again re-exposes a pending request.

Test Plan:
- Reset state: reset with WE=1, Addr=0, Din=32'hF, then reset=0 -> Dout reads 0 for all addresses; IRQ=0.
- One-shot: PRESET=3, then CTRL=32'h9 written at edge t0 -> LOAD at t1; COUNT=3,2,1,0 after t2..t5; IRQ=1 after t5; CTRL reads 32'h8 after t6; IRQ stays 1 until a write of CTRL=32'h8, then falls.
- Auto-reload: PRESET=2, CTRL=32'hB -> IRQ pulses high for exactly 1 cycle, repeating every 4 cycles; COUNT sequence 2,1,0,(INT),2,...
- Mask: one-shot as above with CTRL=32'h1 -> irq_pend sets but IRQ=0; later write CTRL=32'h8 -> irq_pend cleared, IRQ remains 0. Separately, IM set while pending (no write in between; force via a Mode 1 stall) -> IRQ follows IM.
- Freeze: PRESET=10, enable; at COUNT=6 write CTRL=0 -> COUNT holds at 5 or 6 per edge timing, state IDLE; re-enable -> COUNT reloads 10.
- Edge cases:
  - PRESET=0 -> IRQ after exactly 3 edges from enable sampling.
  - Write COUNT=32'h55 -> ignored.
  - Write PRESET in same edge as INT entry, Mode 0 -> IRQ=1 (set wins).
